// File: rtl/sram_req_arb_if.sv
// Requester and controller-side signals of the 23K640 SRAM request arbiter.
// slave = arbiter side, master = side that drives requests and controller responses.
interface sram_req_arb_if;
    logic [1:0]  i_req_valid;
    logic [1:0]  o_req_accept;
    logic [1:0]  i_req_rd_n_wr;
    logic [31:0] i_req_addr;
    logic [15:0] i_req_wdata;
    logic [1:0]  o_req_done;
    logic        o_req_err;
    logic [7:0]  o_req_rdata;
    logic        o_mem_valid;
    logic        o_mem_rd_n_wr;
    logic [15:0] o_mem_addr;
    logic [7:0]  o_mem_wdata;
    logic        i_mem_accept;
    logic        i_mem_done;
    logic [7:0]  i_mem_rdata;

    modport slave (
        input  i_req_valid, i_req_rd_n_wr, i_req_addr, i_req_wdata,
        input  i_mem_accept, i_mem_done, i_mem_rdata,
        output o_req_accept, o_req_done, o_req_err, o_req_rdata,
        output o_mem_valid, o_mem_rd_n_wr, o_mem_addr, o_mem_wdata
    );

    modport master (
        output i_req_valid, i_req_rd_n_wr, i_req_addr, i_req_wdata,
        output i_mem_accept, i_mem_done, i_mem_rdata,
        input  o_req_accept, o_req_done, o_req_err, o_req_rdata,
        input  o_mem_valid, o_mem_rd_n_wr, o_mem_addr, o_mem_wdata
    );
endinterface

// File: rtl/sram_req_arb.sv
// Two-requester round-robin arbiter/sequencer for the 23K640 SPI SRAM controller plus
// its advance pacing divider. Define SRAM_ARB_TIMEOUT_EN to add the transaction watchdog.
module sram_req_arb #(
    parameter int DIV     = 4,
    parameter int TIMEOUT = 4096
) (
    input  logic          i_clk,
    input  logic          i_rst,
    output logic          o_advance,
    sram_req_arb_if.slave bus
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIV - 1);

    logic [1:0]       state_q, state_d;
    logic             last_q, last_d;
    logic             grant_q, grant_d;
    logic             rd_q, rd_d;
    logic [15:0]      addr_q, addr_d;
    logic [7:0]       wdata_q, wdata_d;
    logic [7:0]       rdata_q, rdata_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] div_cnt_q, div_cnt_d;
    logic [1:0]       accept;
    logic             pick;
    logic             wd_expired;
    logic [15:0]      req_addr [2];
    logic [7:0]       req_wdata [2];

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_req
            assign req_addr[gi]  = bus.i_req_addr[16*gi +: 16];
            assign req_wdata[gi] = bus.i_req_wdata[8*gi +: 8];
        end
    endgenerate

    // On contention the requester not served last wins; otherwise the sole valid one.
    assign pick = (bus.i_req_valid == 2'b11) ? ~last_q : bus.i_req_valid[1];

`ifdef SRAM_ARB_TIMEOUT_EN
    localparam int WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT - 1);

    logic [WD_W-1:0] wd_q, wd_d;
    logic            wd_busy;

    // Count sits at zero outside ISSUE/WAIT, so it restarts on every ISSUE entry.
    assign wd_busy    = (state_q == S_ISSUE) || (state_q == S_WAIT);
    assign wd_d       = wd_busy ? wd_q + WD_W'(1) : '0;
    assign wd_expired = wd_busy && (wd_q == WD_MAX);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wd_q <= '0;
        end else begin
            wd_q <= wd_d;
        end
    end
`else
    assign wd_expired = 1'b0;
    if (TIMEOUT < 1) begin : g_timeout_unused
    end
`endif

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        grant_d = grant_q;
        rd_d    = rd_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        accept  = 2'b00;
        case (state_q)
            S_IDLE: begin
                if (bus.i_req_valid != 2'b00) begin
                    accept  = pick ? 2'b10 : 2'b01;
                    grant_d = pick;
                    last_d  = pick;
                    rd_d    = bus.i_req_rd_n_wr[pick];
                    addr_d  = req_addr[pick];
                    wdata_d = req_wdata[pick];
                    err_d   = 1'b0;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (wd_expired) begin
                    rdata_d = 8'h00;
                    err_d   = 1'b1;
                    state_d = S_RESP;
                end else if (bus.i_mem_accept) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                // A real completion beats a watchdog expiry in the same cycle.
                if (bus.i_mem_done) begin
                    rdata_d = rd_q ? bus.i_mem_rdata : 8'h00;
                    err_d   = 1'b0;
                    state_d = S_RESP;
                end else if (wd_expired) begin
                    rdata_d = 8'h00;
                    err_d   = 1'b1;
                    state_d = S_RESP;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign div_cnt_d = (div_cnt_q == CNT_MAX) ? '0 : div_cnt_q + CNT_W'(1);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= S_IDLE;
            last_q    <= 1'b1;
            grant_q   <= 1'b0;
            rd_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
            div_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            grant_q   <= grant_d;
            rd_q      <= rd_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
            err_q     <= err_d;
            div_cnt_q <= div_cnt_d;
        end
    end

    assign o_advance         = !i_rst && (div_cnt_q == CNT_MAX);
    assign bus.o_req_accept  = i_rst ? 2'b00 : accept;
    assign bus.o_mem_valid   = (state_q == S_ISSUE);
    assign bus.o_mem_rd_n_wr = rd_q;
    assign bus.o_mem_addr    = addr_q;
    assign bus.o_mem_wdata   = wdata_q;
    assign bus.o_req_done    = (state_q == S_RESP) ? (grant_q ? 2'b10 : 2'b01) : 2'b00;
    assign bus.o_req_err     = (state_q == S_RESP) && err_q;
    assign bus.o_req_rdata   = (state_q == S_RESP) ? rdata_q : 8'h00;
endmodule

// File: tb/tb_sram_req_arb.sv
// Self-checking bench for sram_req_arb: directed scenarios with literal expectations plus
// randomized traffic compared every cycle against a timestamp-based transaction model.
module tb_sram_req_arb;
    localparam int DIV     = 4;
    localparam int TIMEOUT = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic adv, adv1;

    sram_req_arb_if bus ();
    sram_req_arb_if bus1 ();

    sram_req_arb #(.DIV(DIV), .TIMEOUT(TIMEOUT)) dut (
        .i_clk(clk), .i_rst(rst), .o_advance(adv), .bus(bus)
    );
    sram_req_arb #(.DIV(1), .TIMEOUT(TIMEOUT)) dut1 (
        .i_clk(clk), .i_rst(rst), .o_advance(adv1), .bus(bus1)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    int          cyc = 0;
    int          rel = 0;
    bit          m_busy = 1'b0;
    bit          m_last = 1'b1;
    bit          m_own = 1'b0;
    bit          m_rd = 1'b0;
    bit          m_err = 1'b0;
    bit          prev_rst = 1'b0;
    int          acc_c = 0;
    int          macc_c = -1;
    int          done_c = -1;
    logic [15:0] m_addr = '0;
    logic [7:0]  m_wd = '0;
    logic [7:0]  m_cap = '0;
    logic [1:0]  m_acc_prev = '0;

    always @(negedge clk) begin
        logic [1:0] e_acc;
        logic [1:0] e_done;
        bit         e_mv;
        bit         waiting;
        int         g;
        cyc++;
        if (rst) begin
            if (prev_rst) begin
                chk("rst_accept", 32'(bus.o_req_accept), 32'd0);
                chk("rst_done", 32'(bus.o_req_done), 32'd0);
                chk("rst_err", 32'(bus.o_req_err), 32'd0);
                chk("rst_rdata", 32'(bus.o_req_rdata), 32'd0);
                chk("rst_mem_valid", 32'(bus.o_mem_valid), 32'd0);
                chk("rst_mem_addr", 32'(bus.o_mem_addr), 32'd0);
                chk("rst_mem_wdata", 32'(bus.o_mem_wdata), 32'd0);
                chk("rst_mem_rd", 32'(bus.o_mem_rd_n_wr), 32'd0);
                chk("rst_advance", 32'(adv), 32'd0);
                chk("rst_advance_div1", 32'(adv1), 32'd0);
            end
            m_busy     = 1'b0;
            m_last     = 1'b1;
            rel        = 0;
            m_acc_prev = 2'b00;
        end else begin
            if (m_busy && done_c >= 0 && cyc >= done_c + 2) m_busy = 1'b0;
            e_acc = 2'b00;
            if (!m_busy && bus.i_req_valid != 2'b00) begin
                g      = (bus.i_req_valid == 2'b11) ? int'(!m_last) : int'(bus.i_req_valid[1]);
                e_acc  = (g == 1) ? 2'b10 : 2'b01;
                m_own  = (g == 1);
                m_last = (g == 1);
                m_rd   = bus.i_req_rd_n_wr[g];
                m_addr = bus.i_req_addr[16*g +: 16];
                m_wd   = bus.i_req_wdata[8*g +: 8];
                m_busy = 1'b1;
                acc_c  = cyc;
                macc_c = -1;
                done_c = -1;
            end
            e_mv   = m_busy && cyc > acc_c && macc_c < 0 && done_c < 0;
            e_done = (m_busy && done_c >= 0 && cyc == done_c + 1) ? (m_own ? 2'b10 : 2'b01) : 2'b00;
            chk("accept", 32'(bus.o_req_accept), 32'(e_acc));
            chk("mem_valid", 32'(bus.o_mem_valid), 32'(e_mv));
            chk("req_done", 32'(bus.o_req_done), 32'(e_done));
            if (m_busy && cyc > acc_c && (done_c < 0 || cyc <= done_c)) begin
                chk("mem_addr", 32'(bus.o_mem_addr), 32'(m_addr));
                chk("mem_wdata", 32'(bus.o_mem_wdata), 32'(m_wd));
                chk("mem_rd_n_wr", 32'(bus.o_mem_rd_n_wr), 32'(m_rd));
            end
            if (e_done != 2'b00) begin
                chk("req_rdata", 32'(bus.o_req_rdata), 32'(m_cap));
                chk("req_err", 32'(bus.o_req_err), 32'(m_err));
                $display("txn cyc=%0d req%0d %s addr=%04h wdata=%02h rdata=%02h err=%0d",
                         cyc, int'(m_own), m_rd ? "RD" : "WR", m_addr, m_wd,
                         bus.o_req_rdata, int'(bus.o_req_err));
            end
            chk("advance", 32'(adv), 32'((rel % DIV) == DIV - 1));
            chk("advance_div1", 32'(adv1), 32'd1);
            waiting = m_busy && macc_c >= 0 && cyc > macc_c && done_c < 0;
`ifdef SRAM_ARB_TIMEOUT_EN
            if (m_busy && done_c < 0 && cyc == acc_c + TIMEOUT && !(waiting && bus.i_mem_done)) begin
                done_c = cyc;
                m_err  = 1'b1;
                m_cap  = 8'h00;
            end
`endif
            if (waiting && bus.i_mem_done && done_c < 0) begin
                done_c = cyc;
                m_err  = 1'b0;
                m_cap  = m_rd ? bus.i_mem_rdata : 8'h00;
            end
            if (e_mv && bus.i_mem_accept && done_c < 0) macc_c = cyc;
            m_acc_prev = e_acc;
            rel++;
        end
        prev_rst = rst;
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int p, input bit v, input bit rd, input logic [15:0] a, input logic [7:0] w);
        bus.i_req_valid[p]          = v;
        bus.i_req_rd_n_wr[p]        = rd;
        bus.i_req_addr[16*p +: 16]  = a;
        bus.i_req_wdata[8*p +: 8]   = w;
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        repeat (n) tick();
        rst = 1'b0;
    endtask

    initial begin
        int         adv_at [3];
        int         n_adv;
        logic [1:0] grants [5];
        int         n_gr;

        bus.i_req_valid   = '0;
        bus.i_req_rd_n_wr = '0;
        bus.i_req_addr    = '0;
        bus.i_req_wdata   = '0;
        bus.i_mem_accept  = 1'b0;
        bus.i_mem_done    = 1'b0;
        bus.i_mem_rdata   = '0;
        bus1.i_req_valid   = '0;
        bus1.i_req_rd_n_wr = '0;
        bus1.i_req_addr    = '0;
        bus1.i_req_wdata   = '0;
        bus1.i_mem_accept  = 1'b0;
        bus1.i_mem_done    = 1'b0;
        bus1.i_mem_rdata   = '0;
        #1;
        do_reset(3);

        // Divider: first pulses at cycles 3, 7, 11 after release.
        adv_at = '{-1, -1, -1};
        n_adv  = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (adv) begin
                if (n_adv < 3) adv_at[n_adv] = k;
                n_adv++;
            end
            chk("div1_high", 32'(adv1), 32'd1);
            tick();
        end
        chk("adv_count", 32'(n_adv), 32'd3);
        chk("adv_first", 32'(adv_at[0]), 32'd3);
        chk("adv_second", 32'(adv_at[1]), 32'd7);
        chk("adv_third", 32'(adv_at[2]), 32'd11);

        // Single read by requester 0.
        set_req(0, 1'b1, 1'b1, 16'h1234, 8'h00);
        @(negedge clk); chk("rd_accept", 32'(bus.o_req_accept), 32'h1);
        tick(); set_req(0, 1'b0, 1'b0, 16'h0000, 8'h00);
        @(negedge clk);
        chk("rd_mem_valid", 32'(bus.o_mem_valid), 32'd1);
        chk("rd_mem_addr", 32'(bus.o_mem_addr), 32'h1234);
        chk("rd_mem_rd", 32'(bus.o_mem_rd_n_wr), 32'd1);
        tick(); bus.i_mem_accept = 1'b1;
        @(negedge clk); chk("rd_issue_hold", 32'(bus.o_mem_valid), 32'd1);
        tick(); bus.i_mem_accept = 1'b0;
        @(negedge clk); chk("rd_wait_valid", 32'(bus.o_mem_valid), 32'd0);
        tick(); bus.i_mem_done = 1'b1; bus.i_mem_rdata = 8'hA5;
        @(negedge clk); chk("rd_no_early_done", 32'(bus.o_req_done), 32'd0);
        tick(); bus.i_mem_done = 1'b0; bus.i_mem_rdata = 8'h00;
        @(negedge clk);
        chk("rd_done", 32'(bus.o_req_done), 32'h1);
        chk("rd_rdata", 32'(bus.o_req_rdata), 32'hA5);
        chk("rd_err", 32'(bus.o_req_err), 32'd0);

        // Stray done while idle.
        tick(); bus.i_mem_done = 1'b1;
        @(negedge clk); chk("stray_done_idle", 32'(bus.o_req_done), 32'd0);
        tick(); bus.i_mem_done = 1'b0;
        @(negedge clk);
        chk("stray_done_after", 32'(bus.o_req_done), 32'd0);
        chk("stray_done_mv", 32'(bus.o_mem_valid), 32'd0);

        // Single write by requester 1, with a stray accept while waiting.
        tick(); set_req(1, 1'b1, 1'b0, 16'h7FFF, 8'h3C);
        @(negedge clk); chk("wr_accept", 32'(bus.o_req_accept), 32'h2);
        tick(); set_req(1, 1'b0, 1'b0, 16'h0000, 8'h00); bus.i_mem_accept = 1'b1;
        @(negedge clk);
        chk("wr_mem_addr", 32'(bus.o_mem_addr), 32'h7FFF);
        chk("wr_mem_rd", 32'(bus.o_mem_rd_n_wr), 32'd0);
        for (int k = 0; k < 4; k++) begin
            tick();
            bus.i_mem_accept = (k == 1);
            bus.i_mem_done   = (k == 3);
            bus.i_mem_rdata  = 8'hFF;
            @(negedge clk);
            chk("wr_wdata_held", 32'(bus.o_mem_wdata), 32'h3C);
            chk("wr_wait_no_done", 32'(bus.o_req_done), 32'd0);
        end
        tick(); bus.i_mem_done = 1'b0; bus.i_mem_accept = 1'b0;
        @(negedge clk);
        chk("wr_done", 32'(bus.o_req_done), 32'h2);
        chk("wr_rdata", 32'(bus.o_req_rdata), 32'h00);
        tick();

        // Contention straight after reset: grants alternate starting with requester 0.
        do_reset(2);
        set_req(0, 1'b1, 1'b1, 16'h0100, 8'h00);
        set_req(1, 1'b1, 1'b0, 16'h0200, 8'h55);
        bus.i_mem_accept = 1'b1; bus.i_mem_done = 1'b1; bus.i_mem_rdata = 8'h11;
        n_gr = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (bus.o_req_accept != 2'b00) begin
                if (n_gr < 5) grants[n_gr] = bus.o_req_accept;
                n_gr++;
            end
            tick();
        end
        set_req(0, 1'b0, 1'b0, 16'h0000, 8'h00);
        set_req(1, 1'b0, 1'b0, 16'h0000, 8'h00);
        bus.i_mem_accept = 1'b0; bus.i_mem_done = 1'b0;
        chk("contend_count", 32'(n_gr), 32'd5);
        chk("contend_g0", 32'(grants[0]), 32'h1);
        chk("contend_g1", 32'(grants[1]), 32'h2);
        chk("contend_g2", 32'(grants[2]), 32'h1);
        chk("contend_g3", 32'(grants[3]), 32'h2);
        tick();

        // Reset while waiting on the controller: request is dropped silently.
        set_req(0, 1'b1, 1'b1, 16'h0ABC, 8'h00);
        tick(); set_req(0, 1'b0, 1'b0, 16'h0000, 8'h00); bus.i_mem_accept = 1'b1;
        tick(); bus.i_mem_accept = 1'b0;
        @(negedge clk); chk("mid_rst_waiting", 32'(bus.o_mem_valid), 32'd0);
        tick(); rst = 1'b1;
        tick(); rst = 1'b0; bus.i_mem_done = 1'b1; bus.i_mem_rdata = 8'h77;
        @(negedge clk);
        chk("mid_rst_done", 32'(bus.o_req_done), 32'd0);
        chk("mid_rst_mv", 32'(bus.o_mem_valid), 32'd0);
        chk("mid_rst_addr", 32'(bus.o_mem_addr), 32'd0);
        chk("mid_rst_rdata", 32'(bus.o_req_rdata), 32'd0);
        tick(); bus.i_mem_done = 1'b0;
        @(negedge clk); chk("mid_rst_no_done", 32'(bus.o_req_done), 32'd0);
        tick();

`ifdef SRAM_ARB_TIMEOUT_EN
        // Watchdog: accepted but never completed; abort lands TIMEOUT+1 cycles after the grant.
        set_req(0, 1'b1, 1'b1, 16'h0042, 8'h00);
        for (int k = 0; k < 22; k++) begin
            @(negedge clk);
            if (k > 0) chk("wd_done", 32'(bus.o_req_done), (k == 17) ? 32'h1 : 32'h0);
            if (k == 17) begin
                chk("wd_err", 32'(bus.o_req_err), 32'd1);
                chk("wd_rdata", 32'(bus.o_req_rdata), 32'd0);
            end
            tick();
            if (k == 0) set_req(0, 1'b0, 1'b0, 16'h0000, 8'h00);
            bus.i_mem_accept = (k + 1 == 1);
            bus.i_mem_done   = (k + 1 == 19);
            bus.i_mem_rdata  = 8'h99;
        end
        bus.i_mem_accept = 1'b0; bus.i_mem_done = 1'b0;
`endif

        // Randomized traffic, including stray handshakes and withdrawn requests.
        for (int c = 0; c < 4000; c++) begin
            if (c == 2000) do_reset(1);
            for (int p = 0; p < 2; p++) begin
                if (bus.i_req_valid[p] && m_acc_prev[p]) begin
                    if ($urandom_range(1) == 0) set_req(p, 1'b1, 1'($urandom_range(1)), 16'($urandom), 8'($urandom));
                    else set_req(p, 1'b0, 1'b0, 16'h0000, 8'h00);
                end else if (bus.i_req_valid[p]) begin
                    if ($urandom_range(15) == 0) set_req(p, 1'b0, 1'b0, 16'h0000, 8'h00);
                end else if ($urandom_range(2) == 0) begin
                    set_req(p, 1'b1, 1'($urandom_range(1)), 16'($urandom), 8'($urandom));
                end
            end
            bus.i_mem_accept = ($urandom_range(2) == 0);
            bus.i_mem_done   = ($urandom_range(2) == 0);
            bus.i_mem_rdata  = 8'($urandom);
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/sram_req_arb.md
# sram_req_arb

Two-port request arbiter and sequencer for the 23K640 SPI SRAM controller. Accepts byte read/write requests from two application requesters and grants them round-robin. Issues one transaction at a time to the controller's request port, holding all fields stable until completion, and routes the completion back to the owning requester. Also generates the controller's `advance` pacing strobe from a programmable divider.

## Interface
- `DIV`, 4: cycles per `o_advance` pulse; legal range ≥1.
- `TIMEOUT`, 4096: watchdog limit in cycles; only used with `SRAM_ARB_TIMEOUT_EN`.
- `i_clk` in 1: clock.
- `i_rst` in 1: reset. One clock; reset is synchronous and active-high.
- `o_advance` in→out 1: pacing strobe to the controller, one cycle high every `DIV` cycles.
- `i_req_valid` in 2: per-requester request valid; held until accepted.
- `o_req_accept` out 2: one-hot, one-cycle accept pulse.
- `i_req_rd_n_wr` in 2: per-requester 1=read, 0=write.
- `i_req_addr` in 32: requester p address is bits [16p+15:16p].
- `i_req_wdata` in 16: requester p write data is bits [8p+7:8p].
- `o_req_done` out 2: one-hot, one-cycle completion pulse.
- `o_req_err` out 1: qualifies `o_req_done`; 1 = watchdog abort.
- `o_req_rdata` out 8: read data; valid while `o_req_done` is set.
- `o_mem_valid` out 1: transaction request to the controller.
- `o_mem_rd_n_wr` out 1, `o_mem_addr` out 16, `o_mem_wdata` out 8: held stable from ISSUE entry until the FSM leaves WAIT.
- `i_mem_accept` in 1: controller took the request.
- `i_mem_done` in 1: one-cycle pulse at the end of every transaction, read or write.
- `i_mem_rdata` in 8: read byte; valid with `i_mem_done`.

## Operation
FSM states: IDLE, ISSUE, WAIT, RESP.
- **IDLE**
  - If any `i_req_valid` is set, grant `g`.
  - Arbitration: if both requesters are valid, `g` is the one not equal to `last`; otherwise `g` is the sole valid requester.
  - Assert `o_req_accept[g]` combinationally in this cycle.
  - Capture `rd_n_wr`, `addr` and `wdata` into holding registers; set `last<=g`; go to ISSUE.
- **ISSUE**
  - `o_mem_valid=1`, driven from the holding registers.
  - On `i_mem_accept`: go to WAIT.
- **WAIT**
  - `o_mem_valid=0`; mem fields remain held.
  - On `i_mem_done`: capture `i_mem_rdata` (reads only; writes load 0); go to RESP.
- **RESP**
  - `o_req_done[g]=1`, `o_req_rdata` = captured byte, `o_req_err=0`.
  - Go to IDLE next cycle.
- **Ignored inputs**
  - `i_mem_done` outside WAIT is ignored.
  - `i_mem_accept` outside ISSUE is ignored.
- **Advance divider**
  - Free-running counter, 0..DIV-1, width `$clog2(DIV)` (minimum 1).
  - `o_advance` is high when the count equals DIV-1; the counter wraps to 0.
  - DIV=1 gives `o_advance` constantly high after reset.
  - Independent of the FSM.
- **Requester behaviour**
  - A requester whose valid drops before accept is not serviced; no state is kept for it.
  - Requester fields are sampled only in the accept cycle.

## Timing
- **Reset values**
  - All outputs 0, state IDLE, `last=1` (requester 0 wins the first contention).
  - Divider count 0; the first `o_advance` occurs DIV-1 cycles after reset release (DIV>1).
- **Reset mid-transaction**
  - At the next edge the FSM returns to IDLE and `o_mem_valid` drops.
  - No `o_req_done` is issued.
  - The held request is lost.
- **Latency**
  - Accept in cycle T.
  - `o_mem_valid` high from T+1.
  - If `i_mem_accept` arrives at T+1, WAIT is entered at T+2.
  - `i_mem_done` at cycle D gives `o_req_done` at D+1, and IDLE at D+2.
  - The earliest next accept is D+2.
- **Done/accept ordering:** the controller guarantees `i_mem_done` no earlier than one cycle after `i_mem_accept`.
- **Outstanding transactions:** at most one in flight. Throughput is bounded by the controller.

## Configuration
`SRAM_ARB_TIMEOUT_EN`
- **Defined**
  - A watchdog counter clears on ISSUE entry and increments in ISSUE and WAIT.
  - On reaching TIMEOUT-1 without the FSM leaving WAIT:
    - go to RESP with `o_req_err=1` and `o_req_rdata=0`;
    - `o_mem_valid` deasserts at the same edge.
  - A late `i_mem_done` is then ignored.
- **Undefined**
  - No counter; `o_req_err` is tied 0.
  - The FSM waits in ISSUE/WAIT indefinitely.

## Test plan
- **Single read:** req0 read at addr 0x1234; `i_mem_accept` one cycle after `o_mem_valid`; `i_mem_done` with rdata 0xA5 → `o_mem_addr=0x1234` and `o_mem_rd_n_wr=1`, then `o_req_done=2'b01` with `o_req_rdata=0xA5` exactly one cycle after done.
- **Contention after reset:** both requesters valid in the same cycle after reset → req0 accepted first, then req1. Keep both valid → grants alternate 0,1,0,1 across 4 transactions.
- **Single write:** req1 write at addr 0x7FFF, wdata 0x3C → `o_mem_wdata=0x3C` held stable until done; `o_req_done=2'b10`, `o_req_rdata=0x00`.
- **Stray handshakes:** `i_mem_done` pulsed in IDLE and `i_mem_accept` pulsed in WAIT → no state change, no `o_req_done`.
- **Divider:** DIV=4 → `o_advance` high at cycles 3, 7, 11 after reset release. DIV=1 → `o_advance` constantly high.
- **Watchdog (macro defined):** TIMEOUT=16, accept given but done withheld → `o_req_done` with `o_req_err=1` at the fixed cycle after ISSUE entry. A later `i_mem_done` is ignored. Reset asserted in WAIT → IDLE with all outputs 0 at the next edge.
